module4_fine_cfo_cmul_sched: RTL and testbench
==============================================

// Module: module4_fine_cfo_cmul_sched
// PURPOSE
//  Sequencer that time-shares ONE combinational signed multiplier (27s x 32s -> low 32 bits)
//  across the four real products of a complex fine-CFO derotation, per I/Q sample.
//  Sits in module4_fine_cfo_apply between the NCO (cos/sin) and the sample output stream.
//  Replaces four parallel multipliers with one, at a throughput of 1 sample per 5 cycles.
// PARAMETERS
//  DIN_W    27  signed width of in_i/in_q (multiplier operand A)
//  COEF_W   32  signed width of cos_c/sin_c (multiplier operand B)
//  PROD_W   32  product/output width; product = low PROD_W bits of full signed product
//  CNT_W    16  width of sample_cnt
// PORTS
//  ap_clk      in   1       clock, all logic on rising edge
//  ap_rst_n    in   1       asynchronous active-low reset
//  in_valid    in   1       input sample + coefficients valid
//  in_ready    out  1       block can accept a sample this cycle
//  in_i        in   DIN_W   sample I (signed)
//  in_q        in   DIN_W   sample Q (signed)
//  cos_c       in   COEF_W  NCO cosine (signed), sampled with in_i/in_q
//  sin_c       in   COEF_W  NCO sine (signed), sampled with in_i/in_q
//  out_valid   out  1       derotated sample valid
//  out_ready   in   1       downstream accepts output
//  out_i       out  PROD_W  I*cos + Q*sin
//  out_q       out  PROD_W  Q*cos - I*sin
//  sample_cnt  out  CNT_W   count of completed output handshakes
//  busy        out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset (async, ap_rst_n=0): state=IDLE; in_ready=0 while in reset, 1 in first cycle after;
//   out_valid=0, out_i=0, out_q=0, sample_cnt=0, busy=0. In-flight sample discarded.
//  FSM states: IDLE, M0, M1, M2, M3, OUT.
//   IDLE: in_ready=1. in_valid&in_ready -> latch in_i,in_q,cos_c,sin_c; go M0.
//   M0: mul(I,cos) -> acc_i  (load).            -> M1
//   M1: mul(Q,sin) -> acc_i += p.               -> M2
//   M2: mul(Q,cos) -> acc_q  (load).            -> M3
//   M3: mul(I,sin) -> acc_q -= p.               -> OUT, out_valid=1 next cycle
//   OUT: out_i/out_q held stable with out_valid=1 until out_ready.
//    out_ready & in_valid -> accept new sample same cycle (in_ready=1 in OUT iff out_ready), go M0.
//    out_ready & !in_valid -> IDLE. !out_ready -> stay OUT, in_ready=0.
//  Exactly one multiplier instance, operand mux selected by state; mult is combinational
//   (0 stages), product captured in the accumulator at the end of the same cycle.
//  Latency: accept at cycle 0 -> out_valid at cycle 5. Steady throughput 1 per 5 cycles.
//  Arithmetic: products truncated to low PROD_W bits; add/sub in PROD_W bits, two's-complement
//   wrap (default build). Operands sign-extended to DIN_W+COEF_W before multiply.
//  sample_cnt increments on each out_valid&out_ready; wraps 2^CNT_W-1 -> 0.
//  in_valid while not in_ready: ignored, inputs not latched (upstream must hold).
//  out_i/out_q change only on entry to OUT; stable while out_valid && !out_ready.
// CONFIGURATION
//  FINE_CFO_SAT_EN defined: M1 add and M3 subtract saturate to
//   [-2^(PROD_W-1), 2^(PROD_W-1)-1] instead of wrapping; products still truncated as above.
//  FINE_CFO_SAT_EN undefined: wrap-around arithmetic only; no saturation logic synthesised.
//  Timing and handshake identical in both builds.
// TESTING
//  1 I=3,Q=5,cos=2,sin=0, out_ready=1 -> out_i=6, out_q=10 at cycle 5; sample_cnt=1.
//  2 I=3,Q=5,cos=0,sin=1 -> out_i=5, out_q=-3; I=-4,Q=7,cos=-1,sin=2 -> out_i=18, out_q=1.
//  3 10 back-to-back samples, in_valid=out_ready=1 -> out_valid every 5th cycle, sample_cnt=10.
//  4 out_ready=0 for 8 cycles in OUT -> outputs held, in_ready=0, no new accept; release -> 1 handshake.
//  5 I=Q=2^26-1, cos=sin=2^31-1 -> wrap result (default) vs 2^31-1 / correct saturated value
//    under FINE_CFO_SAT_EN; bench checks against reference model for both builds.
//  6 assert ap_rst_n=0 during M2 -> out_valid=0, sample_cnt=0 immediately; next sample processes cleanly.

Source files
------------

// File: rtl/module4_fine_cfo_cmul_sched.sv
// Fine-CFO derotation sequencer: one shared 27s x 32s multiplier, four products per I/Q sample.
// Ports: ap_clk/ap_rst_n, in_* (sample+NCO, valid/ready), out_* (result, valid/ready), sample_cnt, busy.
// Build option: define FINE_CFO_SAT_EN to saturate the accumulate steps instead of wrapping.
module module4_fine_cfo_cmul_sched #(
  parameter int DIN_W  = 27,
  parameter int COEF_W = 32,
  parameter int PROD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  in_i,
  input  logic signed [DIN_W-1:0]  in_q,
  input  logic signed [COEF_W-1:0] cos_c,
  input  logic signed [COEF_W-1:0] sin_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PROD_W-1:0] out_i,
  output logic signed [PROD_W-1:0] out_q,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_M0   = 3'd1;
  localparam logic [2:0] S_M1   = 3'd2;
  localparam logic [2:0] S_M2   = 3'd3;
  localparam logic [2:0] S_M3   = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0] state_q, state_d;

  logic signed [DIN_W-1:0]  smp_i_q, smp_q_q;
  logic signed [COEF_W-1:0] cos_q, sin_q;
  logic signed [PROD_W-1:0] acc_i_q, acc_q_q;
  logic signed [PROD_W-1:0] out_i_q, out_q_q;
  logic [CNT_W-1:0]         cnt_q;

  logic st_idle, st_m0, st_m1, st_m2, st_m3, st_out;
  logic accept, hshake;

  assign st_idle = (state_q == S_IDLE);
  assign st_m0   = (state_q == S_M0);
  assign st_m1   = (state_q == S_M1);
  assign st_m2   = (state_q == S_M2);
  assign st_m3   = (state_q == S_M3);
  assign st_out  = (state_q == S_OUT);

  // in_ready is forced low while reset is held
  assign in_ready  = ap_rst_n & (st_idle | (st_out & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = st_out;
  assign hshake    = st_out & out_ready;
  assign busy      = ~st_idle;

  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign sample_cnt = cnt_q;

  logic signed [DIN_W-1:0]  op_a;
  logic signed [COEF_W-1:0] op_b;

  always_comb begin
    op_a = smp_i_q;
    op_b = cos_q;
    unique case (1'b1)
      st_m1:   begin op_a = smp_q_q; op_b = sin_q; end
      st_m2:   begin op_a = smp_q_q; op_b = cos_q; end
      st_m3:   begin op_a = smp_i_q; op_b = sin_q; end
      default: begin op_a = smp_i_q; op_b = cos_q; end
    endcase
  end

  // Low PROD_W bits of the full signed product depend only on the low
  // PROD_W bits of the sign-extended operands, so multiply at PROD_W.
  logic signed [PROD_W-1:0] a_ext, b_ext, prod;

  assign a_ext = PROD_W'(op_a);
  assign b_ext = PROD_W'(op_b);
  assign prod  = a_ext * b_ext;

  logic signed [PROD_W-1:0] sum_i, dif_q;

`ifdef FINE_CFO_SAT_EN
  localparam logic signed [PROD_W-1:0] SMAX = {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SMIN = {1'b1, {(PROD_W-1){1'b0}}};

  logic signed [PROD_W:0] sum_x, dif_x;

  assign sum_x = {acc_i_q[PROD_W-1], acc_i_q} + {prod[PROD_W-1], prod};
  assign dif_x = {acc_q_q[PROD_W-1], acc_q_q} - {prod[PROD_W-1], prod};

  // overflow when the extra sign bit disagrees with the result sign
  always_comb begin
    sum_i = sum_x[PROD_W-1:0];
    dif_q = dif_x[PROD_W-1:0];
    if (sum_x[PROD_W] != sum_x[PROD_W-1])
      sum_i = sum_x[PROD_W] ? SMIN : SMAX;
    if (dif_x[PROD_W] != dif_x[PROD_W-1])
      dif_q = dif_x[PROD_W] ? SMIN : SMAX;
  end
`else
  assign sum_i = acc_i_q + prod;
  assign dif_q = acc_q_q - prod;
`endif

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle: if (accept) state_d = S_M0;
      st_m0:   state_d = S_M1;
      st_m1:   state_d = S_M2;
      st_m2:   state_d = S_M3;
      st_m3:   state_d = S_OUT;
      st_out: begin
        if (out_ready)
          state_d = in_valid ? S_M0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      smp_i_q <= '0;
      smp_q_q <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        smp_i_q <= in_i;
        smp_q_q <= in_q;
        cos_q   <= cos_c;
        sin_q   <= sin_c;
      end
      if (st_m0) acc_i_q <= prod;
      if (st_m1) acc_i_q <= sum_i;
      if (st_m2) acc_q_q <= prod;
      if (st_m3) begin
        acc_q_q <= dif_q;
        out_i_q <= acc_i_q;
        out_q_q <= dif_q;
      end
      if (hshake) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_module4_fine_cfo_cmul_sched.sv
// Directed bench for module4_fine_cfo_cmul_sched.
// Table of hand-computed vectors plus back-to-back, stall and mid-sample reset sequences.
module tb_module4_fine_cfo_cmul_sched;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [26:0] in_i, in_q;
  logic signed [31:0] cos_c, sin_c;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_i, out_q;
  logic [15:0]        sample_cnt;
  logic               busy;

  module4_fine_cfo_cmul_sched dut (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_i       (in_i),
    .in_q       (in_q),
    .cos_c      (cos_c),
    .sin_c      (sin_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_i      (out_i),
    .out_q      (out_q),
    .sample_cnt (sample_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [26:0] i;
    logic signed [26:0] q;
    logic signed [31:0] c;
    logic signed [31:0] s;
    logic signed [31:0] ei;
    logic signed [31:0] eq;
  } vec_t;

  vec_t vecs[5];
  int checks;
  int errors;
  logic [15:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_sample(input vec_t v, input string nm);
    bit acc;
    int k;
    in_i = v.i;
    in_q = v.q;
    cos_c = v.c;
    sin_c = v.s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk({nm, "_accept"}, 32'(acc), 32'd1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd4);
    chk({nm, "_out_i"}, out_i, v.ei);
    chk({nm, "_out_q"}, out_q, v.eq);
    @(posedge clk);
    #1;
    exp_cnt++;
    chk({nm, "_cnt"}, 32'(sample_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int nout;
    int last_t;
    int bad_gap;
    int bad_hold;
    int k;

    checks = 0;
    errors = 0;
    exp_cnt = '0;

    vecs[0] = '{27'sd3, 27'sd5, 32'sd2, 32'sd0, 32'sd6, 32'sd10};
    vecs[1] = '{27'sd3, 27'sd5, 32'sd0, 32'sd1, 32'sd5, -32'sd3};
    vecs[2] = '{-27'sd4, 27'sd7, -32'sd1, 32'sd2, 32'sd18, 32'sd1};
    vecs[3] = '{-27'sd100, -27'sd200, 32'sd1000, -32'sd3,
                -32'sd99400, -32'sd200300};
    // (2^26-1)*(2^31-1) truncates to 0x7C000001; doubling overflows
`ifdef FINE_CFO_SAT_EN
    vecs[4] = '{27'sh3FFFFFF, 27'sh3FFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF,
                32'sh7FFFFFFF, 32'sd0};
`else
    vecs[4] = '{27'sh3FFFFFF, 27'sh3FFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF,
                32'shF8000002, 32'sd0};
`endif

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_i = '0;
    in_q = '0;
    cos_c = '0;
    sin_c = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_out_i", out_i, 32'd0);
    chk("rst_out_q", out_q, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++)
      do_sample(vecs[v], $sformatf("vec%0d", v));

    // back-to-back: 1*3+2*4=11, 2*3-1*4=2
    in_i = 27'sd1;
    in_q = 27'sd2;
    cos_c = 32'sd3;
    sin_c = 32'sd4;
    in_valid = 1'b1;
    out_ready = 1'b1;
    nout = 0;
    last_t = 0;
    bad_gap = 0;
    k = 0;
    while (nout < 10 && k < 200) begin
      @(negedge clk);
      k++;
      if (out_valid && out_ready) begin
        if (out_i !== 32'sd11 || out_q !== 32'sd2) bad_gap++;
        if (nout > 0 && (k - last_t) != 5) bad_gap++;
        last_t = k;
        nout++;
        if (nout == 10) in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 16'd10;
    chk("b2b_outputs", 32'(nout), 32'd10);
    chk("b2b_spacing", 32'(bad_gap), 32'd0);
    chk("b2b_cnt", 32'(sample_cnt), 32'(exp_cnt));
    chk("b2b_idle", 32'(busy), 32'd0);

    // stall in OUT for 8 cycles with a competing sample offered
    in_i = 27'sd3;
    in_q = 27'sd5;
    cos_c = 32'sd2;
    sin_c = 32'sd0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("stall_reach_out", 32'(out_valid), 32'd1);
    in_i = 27'sd9;
    in_q = 27'sd9;
    cos_c = 32'sd9;
    sin_c = 32'sd9;
    in_valid = 1'b1;
    bad_hold = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_i !== 32'sd6 || out_q !== 32'sd10)
        bad_hold++;
      @(posedge clk);
      #1;
    end
    chk("stall_hold", 32'(bad_hold), 32'd0);
    chk("stall_cnt", 32'(sample_cnt), 32'(exp_cnt));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    chk("stall_release_cnt", 32'(sample_cnt), 32'(exp_cnt));
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("stall_single_hs", 32'(sample_cnt), 32'(exp_cnt));

    // async reset while in M2
    in_i = 27'sd3;
    in_q = 27'sd5;
    cos_c = 32'sd2;
    sin_c = 32'sd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(sample_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = '0;
    do_sample(vecs[2], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
